// File: rtl/nrisc_pkg.sv
// Shared definitions for the NRISC datapath: ALU opcodes, flag bit positions
// and the default datapath width.
package nrisc_pkg;

    localparam int TAM_DEF = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_RTR = 4'd13;
    localparam logic [3:0] OP_RTL = 4'd14;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/nrisc_ula_shift.sv
// Combinational single-bit shift/rotate unit for the NRISC ALU; returns the
// shifted value and the bit that fell off the end.
module nrisc_ula_shift
    import nrisc_pkg::*;
#(
    parameter int W = TAM_DEF
) (
    input  logic [W-1:0] a,
    input  logic [3:0]   op,
    output logic [W-1:0] res,
    output logic         shout
);

    always_comb begin
        res   = a;
        shout = 1'b0;
        case (op)
            OP_SHR: begin
                res   = {a[W-1], a[W-1:1]};
                shout = a[0];
            end
            OP_SHL: begin
                res   = {a[W-2:0], 1'b0};
                shout = a[W-1];
            end
            OP_RTR: begin
                res   = {a[0], a[W-1:1]};
                shout = a[0];
            end
            OP_RTL: begin
                res   = {a[W-2:0], a[W-1]};
                shout = a[W-1];
            end
            default: begin
                res   = a;
                shout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nrisc_ula.sv
// NRISC ALU: ten operations on two operands, registered result and {N,Z,C}
// flags with one cycle of latency.
module nrisc_ula
    import nrisc_pkg::*;
#(
    parameter int TAM = TAM_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic           incdec,
    input  logic           cmp2,
    input  logic [3:0]     ULA_ctrl,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags
);

    logic [TAM-1:0] out_d, out_q;
    logic [2:0]     flags_d, flags_q;
    logic [TAM-1:0] b_eff;
    logic [TAM:0]   sum_full, diff_full;
    logic [TAM-1:0] shift_res;
    logic           shift_out;
    logic [TAM-1:0] res;
    logic           n_flag, c_flag;

    nrisc_ula_shift #(.W(TAM)) u_shift (
        .a     (ULA_A),
        .op    (ULA_ctrl),
        .res   (shift_res),
        .shout (shift_out)
    );

    // The 17-bit difference's top bit is exactly the unsigned borrow.
    always_comb begin
        b_eff     = incdec ? {{(TAM-1){1'b0}}, 1'b1} : ULA_B;
        sum_full  = {1'b0, ULA_A} + {1'b0, b_eff};
        diff_full = {1'b0, ULA_A} - {1'b0, b_eff};
    end

    always_comb begin
        res    = ULA_A;
        n_flag = 1'b0;
        c_flag = 1'b0;
        case (ULA_ctrl)
            OP_ADD: begin
                res    = sum_full[TAM-1:0];
                c_flag = sum_full[TAM];
                n_flag = sum_full[TAM-1];
            end
            OP_SUB: begin
                res    = diff_full[TAM-1:0];
                c_flag = diff_full[TAM];
                n_flag = diff_full[TAM-1];
            end
            OP_AND: res = ULA_A & ULA_B;
            OP_OR:  res = ULA_A | ULA_B;
            OP_XOR: res = ULA_A ^ ULA_B;
            OP_NOT: res = ~ULA_A;
            OP_SHR: begin
                res    = shift_res;
                c_flag = shift_out;
                n_flag = shift_res[TAM-1];
            end
            OP_SHL: begin
                res    = shift_res;
                c_flag = shift_out;
            end
            OP_RTR, OP_RTL: res = shift_res;
            default: res = ULA_A;
        endcase

        flags_d         = 3'b000;
        flags_d[FLAG_N] = n_flag;
        flags_d[FLAG_Z] = (res == '0);
        flags_d[FLAG_C] = c_flag;

        // A compare updates only the flags; the visible result holds.
        out_d = (ULA_ctrl == OP_SUB && cmp2) ? out_q : res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign ULA_OUT   = out_q;
    assign ULA_flags = flags_q;

endmodule

// File: tb/tb_nrisc_ula.sv
// Self-checking bench for nrisc_ula: a behavioural model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_nrisc_ula;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ULA_A = 16'h0000;
    logic [15:0] ULA_B = 16'h0000;
    logic        incdec = 1'b0;
    logic        cmp2 = 1'b0;
    logic [3:0]  ULA_ctrl = 4'd0;
    logic [15:0] ULA_OUT;
    logic [2:0]  ULA_flags;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_out = 16'h0000;
    logic [2:0]  exp_flags = 3'b000;

    nrisc_ula #(.TAM(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ULA_A     (ULA_A),
        .ULA_B     (ULA_B),
        .incdec    (incdec),
        .cmp2      (cmp2),
        .ULA_ctrl  (ULA_ctrl),
        .ULA_OUT   (ULA_OUT),
        .ULA_flags (ULA_flags)
    );

    always #5 clk = ~clk;

    // Arithmetic model: plain integer math on unsigned operand values.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic inc, input logic cmp,
                                  input logic [3:0] op, input logic [15:0] prev,
                                  output logic [15:0] o, output logic [2:0] f);
        int ua, ub, r;
        logic [15:0] res;
        logic n, c;
        ua = int'(a);
        ub = inc ? 1 : int'(b);
        n = 1'b0;
        c = 1'b0;
        case (op)
            4'd0: begin r = ua + ub; res = r[15:0]; c = (r > 65535); n = res[15]; end
            4'd1: begin r = ua - ub; res = r[15:0]; c = (ua < ub); n = res[15]; end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: begin
                r = ua / 2 + (ua >= 32768 ? 32768 : 0);
                res = r[15:0]; c = (ua % 2 == 1); n = res[15];
            end
            4'd6: begin r = (ua * 2) % 65536; res = r[15:0]; c = (ua >= 32768); end
            4'd7: res = ~a;
            4'd13: begin r = ua / 2 + (ua % 2) * 32768; res = r[15:0]; end
            4'd14: begin r = (ua * 2) % 65536 + ua / 32768; res = r[15:0]; end
            default: res = a;
        endcase
        f = {n, (res == 16'h0000), c};
        o = (op == 4'd1 && cmp) ? prev : res;
    endfunction

    always @(negedge rst) begin
        exp_out   = 16'h0000;
        exp_flags = 3'b000;
    end

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        if (rst) begin
            model(ULA_A, ULA_B, incdec, cmp2, ULA_ctrl, exp_out, exp_out, exp_flags);
            #1;
            checks++;
            if (ULA_OUT !== exp_out || ULA_flags !== exp_flags) begin
                errors++;
                $display("FAIL cycle op=%h got %h/%b want %h/%b", ULA_ctrl, ULA_OUT,
                         ULA_flags, exp_out, exp_flags);
            end
        end
    end

    task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic inc, input logic cmp, input logic [3:0] op,
                         input logic [15:0] want_o, input logic [2:0] want_f);
        @(negedge clk);
        ULA_A = a; ULA_B = b; incdec = inc; cmp2 = cmp; ULA_ctrl = op;
        @(posedge clk);
        #2;
        checks++;
        if (ULA_OUT !== want_o || ULA_flags !== want_f) begin
            errors++;
            $display("FAIL %s got %h/%b want %h/%b", name, ULA_OUT, ULA_flags, want_o, want_f);
        end
        checks++;
        if (exp_out !== want_o || exp_flags !== want_f) begin
            errors++;
            $display("FAIL model_%s model %h/%b want %h/%b", name, exp_out, exp_flags,
                     want_o, want_f);
        end
        $display("op=%h A=%h B=%h inc=%b cmp=%b -> %h/%b", op, a, b, inc, cmp, ULA_OUT, ULA_flags);
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (ULA_OUT !== 16'h0000 || ULA_flags !== 3'b000) begin
            errors++;
            $display("FAIL %s got %h/%b want 0000/000", name, ULA_OUT, ULA_flags);
        end
    endtask

    initial begin
        #2;
        check_reset("reset_initial");
        @(negedge clk);
        rst = 1'b1;

        apply("NOT", 16'hAAAA, 16'h5555, 0, 0, 4'd7,  16'h5555, 3'b000);
        apply("AND", 16'hAAAA, 16'h5555, 0, 0, 4'd2,  16'h0000, 3'b010);
        apply("OR",  16'hAAAA, 16'h5555, 0, 0, 4'd3,  16'hFFFF, 3'b000);
        apply("XOR", 16'hAAAA, 16'h5555, 0, 0, 4'd4,  16'hFFFF, 3'b000);
        apply("ADD", 16'hAAAA, 16'h5555, 0, 0, 4'd0,  16'hFFFF, 3'b100);
        apply("SUB", 16'hAAAA, 16'h5555, 0, 0, 4'd1,  16'h5555, 3'b000);
        apply("SUB_borrow", 16'h0001, 16'h0002, 0, 0, 4'd1, 16'hFFFF, 3'b101);
        apply("ADD_carry",  16'hFFFF, 16'h0001, 0, 0, 4'd0, 16'h0000, 3'b011);
        apply("SHR", 16'hAAAA, 16'h5555, 0, 0, 4'd5,  16'hD555, 3'b100);
        apply("SHL", 16'hAAAA, 16'h5555, 0, 0, 4'd6,  16'h5554, 3'b001);
        apply("RTR", 16'hAAAA, 16'h5555, 0, 0, 4'd13, 16'h5555, 3'b000);
        apply("RTL", 16'hAAAA, 16'h5555, 0, 0, 4'd14, 16'h5555, 3'b000);
        apply("PASS8", 16'hAAAA, 16'h5555, 0, 0, 4'd8, 16'hAAAA, 3'b000);
        apply("PASS15", 16'h8001, 16'h5555, 0, 0, 4'd15, 16'h8001, 3'b000);
        apply("SHR_c", 16'h0003, 16'h0000, 0, 0, 4'd5, 16'h0001, 3'b001);
        apply("RTR_lsb", 16'h0001, 16'h0000, 0, 0, 4'd13, 16'h8000, 3'b000);
        apply("INC", 16'h0007, 16'h5555, 1, 0, 4'd0,  16'h0008, 3'b000);
        apply("DEC", 16'h0007, 16'h5555, 1, 0, 4'd1,  16'h0006, 3'b000);
        apply("CMP", 16'h1234, 16'h1234, 0, 1, 4'd1,  16'h0006, 3'b010);
        apply("CMP_lt", 16'h0001, 16'h0002, 0, 1, 4'd1, 16'h0006, 3'b101);
        apply("INC_and", 16'hAAAA, 16'h5555, 1, 1, 4'd2, 16'h0000, 3'b010);

        // Back-to-back through all ten opcodes, one per cycle.
        apply("b2b_ADD", 16'hAAAA, 16'h5555, 0, 0, 4'd0,  16'hFFFF, 3'b100);
        apply("b2b_SUB", 16'hAAAA, 16'h5555, 0, 0, 4'd1,  16'h5555, 3'b000);
        apply("b2b_AND", 16'hAAAA, 16'h5555, 0, 0, 4'd2,  16'h0000, 3'b010);
        apply("b2b_OR",  16'hAAAA, 16'h5555, 0, 0, 4'd3,  16'hFFFF, 3'b000);
        apply("b2b_XOR", 16'hAAAA, 16'h5555, 0, 0, 4'd4,  16'hFFFF, 3'b000);
        apply("b2b_SHR", 16'hAAAA, 16'h5555, 0, 0, 4'd5,  16'hD555, 3'b100);
        apply("b2b_SHL", 16'hAAAA, 16'h5555, 0, 0, 4'd6,  16'h5554, 3'b001);
        apply("b2b_NOT", 16'hAAAA, 16'h5555, 0, 0, 4'd7,  16'h5555, 3'b000);
        apply("b2b_RTR", 16'hAAAA, 16'h5555, 0, 0, 4'd13, 16'h5555, 3'b000);
        apply("b2b_RTL", 16'hAAAA, 16'h5555, 0, 0, 4'd14, 16'h5555, 3'b000);

        // Mid-cycle asynchronous reset, then recovery on the first edge.
        apply("pre_rst", 16'hAAAA, 16'h5555, 0, 0, 4'd0, 16'hFFFF, 3'b100);
        #1;
        rst = 1'b0;
        #1;
        check_reset("reset_async");
        @(negedge clk);
        #1;
        check_reset("reset_held");
        rst = 1'b1;
        @(posedge clk);
        #2;
        checks++;
        if (ULA_OUT !== 16'hFFFF || ULA_flags !== 3'b100) begin
            errors++;
            $display("FAIL post_rst got %h/%b want FFFF/100", ULA_OUT, ULA_flags);
        end
        apply("post_rst_NOT", 16'hAAAA, 16'h5555, 0, 0, 4'd7, 16'h5555, 3'b000);

        // Randomised sweep checked by the per-cycle model only.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ULA_A    = 16'($urandom);
            ULA_B    = 16'($urandom);
            incdec   = 1'($urandom_range(0, 1));
            cmp2     = 1'($urandom_range(0, 1));
            ULA_ctrl = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
